// File: rtl/fragment_pkg.sv
// Shared definitions for the fragment attribute collector: default widths,
// the read-side state encoding and the per-bank metadata record.
// Bank metadata fields use the widths below, so a different ADDR_WIDTH or
// COORD_WIDTH on the top level must be matched here.
package fragment_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int ADDR_WIDTH  = 4;
    localparam int COORD_WIDTH = 16;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_FETCH  = 2'd1,
        RD_STREAM = 2'd2
    } rd_state_e;

    typedef struct packed {
        logic                   full;
        logic [ADDR_WIDTH-1:0]  count;
        logic [COORD_WIDTH-1:0] x;
        logic [COORD_WIDTH-1:0] y;
    } bank_meta_t;

endpackage

// File: rtl/fragment_bank_ram.sv
// Simple dual-port RAM holding both ping-pong banks. The bank bit is the
// address MSB. Reads are registered: data appears the cycle after i_rd_en.
module fragment_bank_ram
    import fragment_pkg::*;
#(
    parameter int WORD_WIDTH = DATA_WIDTH,
    parameter int BANK_AW    = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [BANK_AW-1:0]    i_wr_addr,
    input  logic [WORD_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [BANK_AW-1:0]    i_rd_addr,
    output logic [WORD_WIDTH-1:0] o_rd_data
);

    logic [WORD_WIDTH-1:0] r_mem [0:(1<<BANK_AW)-1];

    // Write port: store the incoming attribute word.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read port: registered read, held until the next read is issued.
    always_ff @(posedge clk) begin
        if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule

// File: rtl/fragment_attr_collector.sv
// Ping-pong fragment attribute collector. The interpolator fills one bank
// while the other bank is replayed as a valid/ready word stream with
// coordinate tags. The read path is RAM read stage -> skid -> output register,
// giving one word per cycle under continuous out_ready.
// Optional feature macro: FRAG_COLLECTOR_OVERFLOW_CHECK_EN (drop writes and
// done pulses aimed at a full bank and raise a sticky overflow flag).
module fragment_attr_collector
    import fragment_pkg::*;
#(
    parameter int DATA_WIDTH  = fragment_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH  = fragment_pkg::ADDR_WIDTH,
    parameter int COORD_WIDTH = fragment_pkg::COORD_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  frag_attr_wr_data,
    input  logic [ADDR_WIDTH-1:0]  frag_attr_wr_addr,
    input  logic                   frag_attr_wr_en,
    input  logic                   interp_done,
    input  logic [ADDR_WIDTH-1:0]  vertexSize,
    input  logic [COORD_WIDTH-1:0] frag_x,
    input  logic [COORD_WIDTH-1:0] frag_y,
    output logic                   can_accept,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [ADDR_WIDTH-1:0]  out_addr,
    output logic                   out_first,
    output logic                   out_last,
    output logic [COORD_WIDTH-1:0] out_x,
    output logic [COORD_WIDTH-1:0] out_y,
    output logic                   overflow
);

    localparam logic [1:0] ST_IDLE   = RD_IDLE;
    localparam logic [1:0] ST_FETCH  = RD_FETCH;
    localparam logic [1:0] ST_STREAM = RD_STREAM;

    bank_meta_t             r_meta [2];
    logic                   r_wrBank;
    logic                   r_rdBank;
    logic [1:0]             r_state;
    logic [ADDR_WIDTH-1:0]  r_issueIdx;
    logic [ADDR_WIDTH-1:0]  r_curCount;
    logic [COORD_WIDTH-1:0] r_curX;
    logic [COORD_WIDTH-1:0] r_curY;

    logic                   r_ramVld;
    logic [ADDR_WIDTH-1:0]  r_ramAddr;
    logic [DATA_WIDTH-1:0]  w_ramData;

    logic                   r_skidVld;
    logic [DATA_WIDTH-1:0]  r_skidData;
    logic [ADDR_WIDTH-1:0]  r_skidAddr;
    logic                   r_skidFirst;
    logic                   r_skidLast;

    logic                   r_outValid;
    logic [DATA_WIDTH-1:0]  r_outData;
    logic [ADDR_WIDTH-1:0]  r_outAddr;
    logic                   r_outFirst;
    logic                   r_outLast;

    logic                   w_wrBlocked;
    logic                   w_wrEn;
    logic                   w_doneAccept;
    logic                   w_pop;
    logic                   w_outFree;
    logic                   w_skidNextVld;
    logic                   w_skidLoad;
    logic                   w_issue;
    logic [ADDR_WIDTH-1:0]  w_rdIdx;
    logic                   w_ramFirst;
    logic                   w_ramLast;
    logic                   w_lastHs;

`ifdef FRAG_COLLECTOR_OVERFLOW_CHECK_EN
    assign w_wrBlocked = r_meta[r_wrBank].full;

    // Sticky flag: any write or done aimed at a full write bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if ((frag_attr_wr_en || interp_done) && r_meta[r_wrBank].full) begin
            overflow <= 1'b1;
        end
    end
`else
    assign w_wrBlocked = 1'b0;
    assign overflow    = 1'b0;
`endif

    assign w_wrEn       = frag_attr_wr_en && !w_wrBlocked;
    assign w_doneAccept = interp_done && (vertexSize != '0) && !w_wrBlocked;
    assign can_accept   = !r_meta[r_wrBank].full;

    // Output-side handshake bookkeeping. The skid must be empty after this
    // edge before another read is issued, so an in-flight word always has a slot.
    assign w_pop         = r_outValid && out_ready;
    assign w_outFree     = !r_outValid || w_pop;
    assign w_skidNextVld = r_skidVld ? (!w_outFree || r_ramVld) : (r_ramVld && !w_outFree);
    assign w_skidLoad    = r_ramVld && (r_skidVld ? w_outFree : !w_outFree);
    assign w_ramFirst    = (r_ramAddr == '0);
    assign w_ramLast     = (r_ramAddr == r_curCount - ADDR_WIDTH'(1));
    assign w_lastHs      = w_pop && r_outLast && (r_state == ST_STREAM);

    // Decide whether a RAM read is issued this cycle and for which index.
    always_comb begin
        w_issue = 1'b0;
        w_rdIdx = '0;
        case (r_state)
            ST_IDLE: begin
                w_issue = r_meta[r_rdBank].full;
            end
            ST_FETCH, ST_STREAM: begin
                w_issue = (r_issueIdx < r_curCount) && !w_skidNextVld;
                w_rdIdx = r_issueIdx;
            end
            default: begin
                w_issue = 1'b0;
            end
        endcase
    end

    fragment_bank_ram #(
        .WORD_WIDTH (DATA_WIDTH),
        .BANK_AW    (ADDR_WIDTH + 1)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wrEn),
        .i_wr_addr ({r_wrBank, frag_attr_wr_addr}),
        .i_wr_data (frag_attr_wr_data),
        .i_rd_en   (w_issue),
        .i_rd_addr ({r_rdBank, w_rdIdx}),
        .o_rd_data (w_ramData)
    );

    // Bank metadata: completed fragments mark their bank full, the final
    // handshake of a replay frees the read bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta[0] <= '0;
            r_meta[1] <= '0;
            r_wrBank  <= 1'b0;
        end else begin
            if (w_lastHs) begin
                r_meta[r_rdBank].full <= 1'b0;
            end
            if (w_doneAccept) begin
                r_meta[r_wrBank] <= '{full: 1'b1, count: vertexSize, x: frag_x, y: frag_y};
                r_wrBank         <= ~r_wrBank;
            end
        end
    end

    // Read FSM: start a replay when the read bank fills, walk the issue
    // index, and hand the bank back after its last word is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_rdBank   <= 1'b0;
            r_issueIdx <= '0;
            r_curCount <= '0;
            r_curX     <= '0;
            r_curY     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_issue) begin
                        r_state    <= ST_FETCH;
                        r_issueIdx <= ADDR_WIDTH'(1);
                        r_curCount <= r_meta[r_rdBank].count;
                        r_curX     <= r_meta[r_rdBank].x;
                        r_curY     <= r_meta[r_rdBank].y;
                    end
                end
                ST_FETCH: begin
                    r_state <= ST_STREAM;
                    if (w_issue) begin
                        r_issueIdx <= r_issueIdx + ADDR_WIDTH'(1);
                    end
                end
                ST_STREAM: begin
                    if (w_issue) begin
                        r_issueIdx <= r_issueIdx + ADDR_WIDTH'(1);
                    end
                    if (w_lastHs) begin
                        r_state  <= ST_IDLE;
                        r_rdBank <= ~r_rdBank;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // RAM read stage tracking: which index the RAM output currently holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ramVld  <= 1'b0;
            r_ramAddr <= '0;
        end else begin
            r_ramVld <= w_issue;
            if (w_issue) begin
                r_ramAddr <= w_rdIdx;
            end
        end
    end

    // Output register and skid: the output only changes when it is empty or
    // being accepted, the skid catches a word that arrives during a stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_outValid  <= 1'b0;
            r_outData   <= '0;
            r_outAddr   <= '0;
            r_outFirst  <= 1'b0;
            r_outLast   <= 1'b0;
            r_skidVld   <= 1'b0;
            r_skidData  <= '0;
            r_skidAddr  <= '0;
            r_skidFirst <= 1'b0;
            r_skidLast  <= 1'b0;
        end else begin
            if (w_outFree) begin
                if (r_skidVld) begin
                    r_outValid <= 1'b1;
                    r_outData  <= r_skidData;
                    r_outAddr  <= r_skidAddr;
                    r_outFirst <= r_skidFirst;
                    r_outLast  <= r_skidLast;
                end else if (r_ramVld) begin
                    r_outValid <= 1'b1;
                    r_outData  <= w_ramData;
                    r_outAddr  <= r_ramAddr;
                    r_outFirst <= w_ramFirst;
                    r_outLast  <= w_ramLast;
                end else begin
                    r_outValid <= 1'b0;
                end
            end
            r_skidVld <= w_skidNextVld;
            if (w_skidLoad) begin
                r_skidData  <= w_ramData;
                r_skidAddr  <= r_ramAddr;
                r_skidFirst <= w_ramFirst;
                r_skidLast  <= w_ramLast;
            end
        end
    end

    assign out_valid = r_outValid;
    assign out_data  = r_outData;
    assign out_addr  = r_outAddr;
    assign out_first = r_outFirst;
    assign out_last  = r_outLast;
    assign out_x     = r_curX;
    assign out_y     = r_curY;

endmodule
